// File: rtl/uart_csr_pkg.sv
// Shared constants, DFH layout, response codes and FSM states for the UART CSR responder.
package uart_csr_pkg;

  localparam logic [11:0] DFH_OFF        = 12'h000;
  localparam logic [11:0] GUID_L_OFF     = 12'h008;
  localparam logic [11:0] GUID_H_OFF     = 12'h010;
  localparam logic [11:0] UART_BASE_OFF  = 12'h100;
  localparam logic [11:0] UART_WIN_BYTES = 12'h020;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  feature_type;
    logic [18:0] reserved;
    logic        eol;
    logic [23:0] next_offset;
    logic [3:0]  rev;
    logic [11:0] id;
  } dfh_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_BRESP,
    ST_RRESP
  } state_t;

  function automatic dfh_t build_dfh(input logic [11:0] id, input logic [3:0] rev,
                                     input logic [23:0] next_offset, input logic eol);
    dfh_t d;
    d.feature_type = 4'h3;
    d.reserved     = '0;
    d.eol          = eol;
    d.next_offset  = next_offset;
    d.rev          = rev;
    d.id           = id;
    return d;
  endfunction

endpackage

// File: rtl/uart_csr_responder_if.sv
// AXI4-Lite subordinate bus bundle for the UART CSR window.
interface uart_csr_responder_if #(
  parameter int ADDR_W = 12
);
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic [63:0]       s_wdata;
  logic [7:0]        s_wstrb;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid;
  logic              s_rready;
  logic [63:0]       s_rdata;
  logic [1:0]        s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/uart_csr_fwd.sv
// Byte-wide req/ack forward engine toward the UART core.
// Optional no-ack timeout enabled by UART_CSR_FWD_TIMEOUT_EN.
module uart_csr_fwd #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       start_we,
  input  logic [2:0] start_addr,
  input  logic [7:0] start_wdata,
  output logic       uart_req,
  output logic       uart_we,
  output logic [2:0] uart_addr,
  output logic [7:0] uart_wdata,
  input  logic       uart_ack,
  input  logic [7:0] uart_rdata,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rdata_byte
);

  logic       busy_reg;
  logic       we_reg;
  logic [2:0] addr_reg;
  logic [7:0] wdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      we_reg    <= start_we;
      addr_reg  <= start_addr;
      wdata_reg <= start_wdata;
    end else if (done || timeout) begin
      busy_reg  <= 1'b0;
    end
  end

  assign uart_req   = busy_reg;
  assign uart_we    = we_reg;
  assign uart_addr  = addr_reg;
  assign uart_wdata = wdata_reg;
  // An ack arriving while idle is a spurious strobe and never completes anything.
  assign done       = busy_reg & uart_ack;
  assign rdata_byte = uart_rdata;

`ifdef UART_CSR_FWD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt_reg <= '0;
    end else if (busy_reg) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Fires on the last waiting cycle; an ack in that same cycle still wins.
  assign timeout = busy_reg & ~uart_ack & (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/uart_csr_responder.sv
// AXI4-Lite target for the UART feature window: local DFH/GUID plus forwarded 16550 registers.
// Build option: UART_CSR_FWD_TIMEOUT_EN adds a forward timeout returning SLVERR.
module uart_csr_responder
  import uart_csr_pkg::*;
#(
  parameter int           ADDR_W          = 12,
  parameter logic [11:0]  FEATURE_ID      = 12'h024,
  parameter logic [3:0]   FEATURE_REV     = 4'h0,
  parameter logic [23:0]  NEXT_DFH_OFFSET = 24'h010000,
  parameter logic         END_OF_LIST     = 1'b0,
  parameter logic [127:0] FEATURE_GUID    = 128'h0,
  parameter int           TIMEOUT_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       rst,
  uart_csr_responder_if.slave s_axil,
  output logic       uart_req,
  output logic       uart_we,
  output logic [2:0] uart_addr,
  output logic [7:0] uart_wdata,
  input  logic       uart_ack,
  input  logic [7:0] uart_rdata
);

  state_t      state_reg, state_next;
  logic [1:0]  bresp_reg, bresp_next;
  logic [1:0]  rresp_reg, rresp_next;
  logic [63:0] rdata_reg, rdata_next;

  logic [ADDR_W-1:0] aw_off, ar_off;
  logic        wr_both, wr_fire, rd_fire;
  logic        aw_uart, ar_uart, aw_lane_hi, strb_hit;
  logic        fwd_start, fwd_done, fwd_timeout;
  logic [7:0]  fwd_wdata_in, fwd_rbyte;
  logic [2:0]  fwd_addr_in;
  logic [63:0] dfh_word, local_rdata;

  function automatic logic in_uart_win(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(UART_BASE_OFF)) && (a < ADDR_W'(UART_BASE_OFF + UART_WIN_BYTES));
  endfunction

  // Byte-offset low bits are don't-care: misaligned accesses hit the containing word.
  assign aw_off     = {s_axil.s_awaddr[ADDR_W-1:2], 2'b00};
  assign ar_off     = {s_axil.s_araddr[ADDR_W-1:2], 2'b00};
  assign aw_uart    = in_uart_win(aw_off);
  assign ar_uart    = in_uart_win(ar_off);
  assign aw_lane_hi = s_axil.s_awaddr[2];
  assign strb_hit   = aw_lane_hi ? s_axil.s_wstrb[4] : s_axil.s_wstrb[0];

  assign wr_both = s_axil.s_awvalid & s_axil.s_wvalid;
  assign wr_fire = (state_reg == ST_IDLE) & wr_both;
  assign rd_fire = (state_reg == ST_IDLE) & s_axil.s_arvalid & ~wr_both;

  assign fwd_start    = (wr_fire & aw_uart & strb_hit) | (rd_fire & ar_uart);
  assign fwd_addr_in  = wr_fire ? s_axil.s_awaddr[4:2] : s_axil.s_araddr[4:2];
  assign fwd_wdata_in = aw_lane_hi ? s_axil.s_wdata[39:32] : s_axil.s_wdata[7:0];

  assign dfh_word = build_dfh(FEATURE_ID, FEATURE_REV, NEXT_DFH_OFFSET, END_OF_LIST);

  always_comb begin
    local_rdata = '0;
    if (ar_off == ADDR_W'(DFH_OFF)) begin
      local_rdata = dfh_word;
    end else if (ar_off == ADDR_W'(GUID_L_OFF)) begin
      local_rdata = FEATURE_GUID[63:0];
    end else if (ar_off == ADDR_W'(GUID_H_OFF)) begin
      local_rdata = FEATURE_GUID[127:64];
    end
  end

  uart_csr_fwd #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fwd (
    .clk         (clk),
    .rst         (rst),
    .start       (fwd_start),
    .start_we    (wr_fire),
    .start_addr  (fwd_addr_in),
    .start_wdata (fwd_wdata_in),
    .uart_req    (uart_req),
    .uart_we     (uart_we),
    .uart_addr   (uart_addr),
    .uart_wdata  (uart_wdata),
    .uart_ack    (uart_ack),
    .uart_rdata  (uart_rdata),
    .done        (fwd_done),
    .timeout     (fwd_timeout),
    .rdata_byte  (fwd_rbyte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      bresp_reg <= RESP_OKAY;
      rresp_reg <= RESP_OKAY;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      bresp_reg <= bresp_next;
      rresp_reg <= rresp_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bresp_next       = bresp_reg;
    rresp_next       = rresp_reg;
    rdata_next       = rdata_reg;
    s_axil.s_awready = 1'b0;
    s_axil.s_wready  = 1'b0;
    s_axil.s_arready = 1'b0;
    s_axil.s_bvalid  = 1'b0;
    s_axil.s_rvalid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Write wins a same-cycle tie; the read keeps waiting with arready low.
        s_axil.s_awready = wr_both;
        s_axil.s_wready  = wr_both;
        s_axil.s_arready = s_axil.s_arvalid & ~wr_both;
        if (wr_fire) begin
          bresp_next = RESP_OKAY;
          state_next = (aw_uart && strb_hit) ? ST_FWD : ST_BRESP;
        end else if (rd_fire) begin
          rresp_next = RESP_OKAY;
          if (ar_uart) begin
            state_next = ST_FWD;
          end else begin
            rdata_next = local_rdata;
            state_next = ST_RRESP;
          end
        end
      end
      ST_FWD: begin
        if (fwd_done) begin
          if (uart_we) begin
            bresp_next = RESP_OKAY;
            state_next = ST_BRESP;
          end else begin
            rresp_next = RESP_OKAY;
            rdata_next = uart_addr[0] ? {24'h0, fwd_rbyte, 32'h0} : {56'h0, fwd_rbyte};
            state_next = ST_RRESP;
          end
        end else if (fwd_timeout) begin
          if (uart_we) begin
            bresp_next = RESP_SLVERR;
            state_next = ST_BRESP;
          end else begin
            rresp_next = RESP_SLVERR;
            rdata_next = '1;
            state_next = ST_RRESP;
          end
        end
      end
      ST_BRESP: begin
        s_axil.s_bvalid = 1'b1;
        if (s_axil.s_bready) state_next = ST_IDLE;
      end
      ST_RRESP: begin
        s_axil.s_rvalid = 1'b1;
        if (s_axil.s_rready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign s_axil.s_bresp = bresp_reg;
  assign s_axil.s_rresp = rresp_reg;
  assign s_axil.s_rdata = rdata_reg;

  logic unused_bits;
  assign unused_bits = ^{s_axil.s_awaddr[1:0], s_axil.s_araddr[1:0],
                         s_axil.s_wdata[63:40], s_axil.s_wdata[31:8],
                         s_axil.s_wstrb[7:5], s_axil.s_wstrb[3:1]};

endmodule

// File: tb/tb_uart_csr_responder.sv
// Directed bench for uart_csr_responder: local DFH/GUID, forwarded UART accesses, arbitration, reset.
module tb_uart_csr_responder;

  localparam logic [127:0] GUID = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
  localparam logic [63:0]  DFH_EXP = 64'h3000_0001_0000_0024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_csr_responder_if #(.ADDR_W(12)) bus ();

  logic       uart_req, uart_we;
  logic [2:0] uart_addr;
  logic [7:0] uart_wdata;
  logic       uart_ack = 1'b0;
  logic [7:0] uart_rdata = 8'h00;

  uart_csr_responder #(
    .ADDR_W       (12),
    .FEATURE_GUID (GUID)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axil     (bus),
    .uart_req   (uart_req),
    .uart_we    (uart_we),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_ack   (uart_ack),
    .uart_rdata (uart_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // UART core model: acks ack_delay cycles after req rises, records what was forwarded.
  bit         core_en = 1'b0;
  int         ack_delay = 0;
  logic [7:0] core_rdata = 8'h00;
  bit         spurious_ack = 1'b0;
  logic       req_prev = 1'b0;
  int         age = 0;
  int         req_count = 0;
  int         req_cyc = 0;
  int         ack_cyc = 0;
  int         unstable = 0;
  logic       cap_we = 1'b0;
  logic [2:0] cap_addr = 3'd0;
  logic [7:0] cap_wdata = 8'h00;

  always @(negedge clk) begin
    uart_ack = spurious_ack;
    if (uart_req && !req_prev) begin
      req_count++;
      req_cyc   = cyc;
      cap_we    = uart_we;
      cap_addr  = uart_addr;
      cap_wdata = uart_wdata;
      age       = 0;
    end else if (uart_req && (uart_we !== cap_we || uart_addr !== cap_addr ||
                              uart_wdata !== cap_wdata)) begin
      unstable++;
    end
    if (uart_req && core_en) begin
      if (age == ack_delay) begin
        uart_ack   = 1'b1;
        uart_rdata = core_rdata;
        ack_cyc    = cyc;
      end
      age++;
    end
    req_prev = uart_req;
  end

  logic [63:0] last_data;
  logic [1:0]  last_resp;
  int          last_hs, last_done;
  bit          last_ok;

  task automatic axi_read(input logic [11:0] addr, input bit late_ack);
    int budget;
    last_ok = 1'b1;
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    #1;
    budget = 0;
    while (!bus.s_arready && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) last_ok = 1'b0;
    last_hs = cyc;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    budget = 0;
    while (!bus.s_rvalid && budget < 2000) begin @(negedge clk); budget++; end
    if (budget >= 2000) last_ok = 1'b0;
    last_done = cyc;
    if (late_ack) begin
      spurious_ack = 1'b1;
      repeat (2) @(negedge clk);
      spurious_ack = 1'b0;
      @(negedge clk);
    end
    last_data = bus.s_rdata;
    last_resp = bus.s_rresp;
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
    $display("txn rd addr=%h data=%h resp=%0d lat=%0d ok=%0d", addr, last_data, last_resp,
             last_done - last_hs, last_ok);
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int budget;
    last_ok = 1'b1;
    bus.s_awaddr  = addr;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    #1;
    budget = 0;
    while (!(bus.s_awready && bus.s_wready) && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) last_ok = 1'b0;
    last_hs = cyc;
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    budget = 0;
    while (!bus.s_bvalid && budget < 2000) begin @(negedge clk); budget++; end
    if (budget >= 2000) last_ok = 1'b0;
    last_done = cyc;
    last_resp = bus.s_bresp;
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    $display("txn wr addr=%h data=%h strb=%h resp=%0d lat=%0d ok=%0d", addr, data, strb,
             last_resp, last_done - last_hs, last_ok);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, b_cyc, ar_hs, ar_seen, budget;
    bit rv_seen;
    bus.s_awvalid = 1'b0; bus.s_awaddr = '0; bus.s_wvalid = 1'b0; bus.s_wdata = '0;
    bus.s_wstrb = '0; bus.s_bready = 1'b0; bus.s_arvalid = 1'b0; bus.s_araddr = '0;
    bus.s_rready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ctrl", 64'({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid,
                          bus.s_rvalid, uart_req}), 64'h0);
    check("rst_resp", 64'({bus.s_bresp, bus.s_rresp}), 64'h0);
    check("rst_rdata", bus.s_rdata, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Local header reads
    axi_read(12'h000, 1'b0);
    check("dfh_data", last_data, DFH_EXP);
    check("dfh_resp", 64'(last_resp), 64'h0);
    check("dfh_lat", 64'(last_done - last_hs), 64'd1);
    axi_read(12'h010, 1'b0);
    check("guid_h", last_data, GUID[127:64]);
    axi_read(12'h00B, 1'b0);
    check("guid_l_misaligned", last_data, GUID[63:0]);
    axi_read(12'h200, 1'b0);
    check("unmapped_rd", last_data, 64'h0);
    check("unmapped_resp", 64'(last_resp), 64'h0);
    axi_read(12'h004, 1'b0);
    check("unmapped_004", last_data, 64'h0);

    // Forwarded write, lane 0, ack three cycles after req
    core_en = 1'b1; ack_delay = 3;
    n0 = req_count;
    axi_write(12'h108, 64'h0000_0000_0000_005A, 8'h01);
    check("wr108_fwd_count", 64'(req_count - n0), 64'd1);
    check("wr108_fwd", 64'({cap_we, cap_addr, cap_wdata}), 64'({1'b1, 3'd2, 8'h5A}));
    check("wr108_req_lat", 64'(req_cyc - last_hs), 64'd1);
    check("wr108_ack_delay", 64'(ack_cyc - req_cyc), 64'd3);
    check("wr108_b_after_ack", 64'(last_done - ack_cyc), 64'd1);
    check("wr108_resp", 64'(last_resp), 64'h0);

    // Strobe off for the addressed lane: no forward, immediate response
    n0 = req_count;
    axi_write(12'h104, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    check("wr104_nofwd", 64'(req_count - n0), 64'd0);
    check("wr104_lat", 64'(last_done - last_hs), 64'd1);

    // Upper lane write, ack in the same cycle req rises
    ack_delay = 0;
    axi_write(12'h11C, 64'h0000_00A5_0000_0000, 8'h10);
    check("wr11c_fwd", 64'({cap_we, cap_addr, cap_wdata}), 64'({1'b1, 3'd7, 8'hA5}));
    check("wr11c_b_after_ack", 64'(last_done - ack_cyc), 64'd1);

    // Forwarded reads
    ack_delay = 2; core_rdata = 8'hC3;
    axi_read(12'h114, 1'b0);
    check("rd114_data", last_data, 64'h0000_00C3_0000_0000);
    check("rd114_fwd", 64'({cap_we, cap_addr}), 64'({1'b0, 3'd5}));
    check("rd114_req_lat", 64'(req_cyc - last_hs), 64'd1);
    check("rd114_r_after_ack", 64'(last_done - ack_cyc), 64'd1);
    check("rd114_resp", 64'(last_resp), 64'h0);
    ack_delay = 0; core_rdata = 8'h81;
    axi_read(12'h100, 1'b0);
    check("rd100_data", last_data, 64'h0000_0000_0000_0081);
    check("rd100_r_after_ack", 64'(last_done - ack_cyc), 64'd1);

    // Header writes are dropped
    n0 = req_count;
    axi_write(12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    check("wr_dfh_resp", 64'(last_resp), 64'h0);
    check("wr_dfh_nofwd", 64'(req_count - n0), 64'd0);
    axi_read(12'h000, 1'b0);
    check("dfh_after_wr", last_data, DFH_EXP);

    // Spurious ack while idle
    n0 = req_count;
    spurious_ack = 1'b1;
    repeat (3) @(negedge clk);
    spurious_ack = 1'b0;
    @(negedge clk);
    check("spurious_idle", 64'({bus.s_bvalid, bus.s_rvalid, uart_req}), 64'h0);
    check("spurious_nofwd", 64'(req_count - n0), 64'd0);

    // Same-cycle write and read to 0x100: write first, read after B handshake
    ack_delay = 1; core_rdata = 8'h7E;
    bus.s_awaddr = 12'h100; bus.s_wdata = 64'h33; bus.s_wstrb = 8'h01;
    bus.s_araddr = 12'h100;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    #1;
    check("tie_ready", 64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'b110);
    @(negedge clk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    ar_seen = 0; budget = 0;
    while (!bus.s_bvalid && budget < 50) begin
      if (bus.s_arready) ar_seen++;
      @(negedge clk); budget++;
    end
    check("tie_b_bound", 64'(budget < 50), 64'd1);
    if (bus.s_arready) ar_seen++;
    b_cyc = cyc;
    check("tie_first_is_write", 64'({cap_we, cap_wdata}), 64'({1'b1, 8'h33}));
    bus.s_bready = 1'b1;
    @(negedge clk);
    bus.s_bready = 1'b0;
    budget = 0;
    while (!bus.s_arready && budget < 50) begin @(negedge clk); budget++; end
    ar_hs = cyc;
    check("tie_ar_held", 64'(ar_seen), 64'd0);
    check("tie_ar_after_b", 64'(ar_hs - b_cyc), 64'd1);
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    budget = 0;
    while (!bus.s_rvalid && budget < 50) begin @(negedge clk); budget++; end
    check("tie_rd_data", bus.s_rdata, 64'h0000_0000_0000_007E);
    check("tie_rd_fwd_we", 64'(cap_we), 64'd0);
    bus.s_rready = 1'b1;
    @(negedge clk);
    bus.s_rready = 1'b0;
    $display("txn tie wr+rd addr=100 b_cyc=%0d ar_cyc=%0d", b_cyc, ar_hs);

`ifdef UART_CSR_FWD_TIMEOUT_EN
    // No ack: timeout after 256 cycles, late ack ignored
    core_en = 1'b0;
    n0 = req_count;
    axi_read(12'h100, 1'b1);
    check("to_bound", 64'(last_ok), 64'd1);
    check("to_req_duration", 64'(last_done - req_cyc), 64'd256);
    check("to_resp", 64'(last_resp), 64'h2);
    check("to_data", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_req_count", 64'(req_count - n0), 64'd1);
    check("to_req_dropped", 64'(uart_req), 64'd0);
    axi_read(12'h010, 1'b0);
    check("to_followup", last_data, GUID[127:64]);
`endif

    // Reset in the middle of a forward abandons it
    core_en = 1'b0;
    bus.s_araddr = 12'h100; bus.s_arvalid = 1'b1;
    #1;
    budget = 0;
    while (!bus.s_arready && budget < 50) begin @(negedge clk); budget++; end
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    check("rstfwd_req_on", 64'(uart_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstfwd_req_off", 64'({uart_req, bus.s_rvalid}), 64'h0);
    rst = 1'b0;
    rv_seen = 1'b0;
    repeat (4) begin @(negedge clk); rv_seen |= bus.s_rvalid; end
    check("rstfwd_no_r", 64'(rv_seen), 64'd0);
    $display("txn rd addr=100 abandoned by reset");
    axi_read(12'h008, 1'b0);
    check("rstfwd_guid_l", last_data, GUID[63:0]);
    check("rstfwd_guid_resp", 64'(last_resp), 64'h0);

    check("fwd_fields_stable", 64'(unstable), 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_csr_responder.md
Name: uart_csr_responder

Overview:
- AXI4-Lite subordinate that answers host MMIO to the UART feature window (BAR0, base 0x60000).
- Serves a read-only DFH/GUID header from local registers.
- Forwards 16550-style register accesses to the UART core over a simple byte-wide req/ack port.
- Sits between the PF0 CSR fabric and the UART core; it is the target side of the host-initiated CSR reads/writes issued by the unit test bench.

Parameters:
- ADDR_W, 12: local byte-offset width (window-relative address).
- FEATURE_ID, 12'h024: DFH feature ID.
- FEATURE_REV, 4'h0: DFH revision.
- NEXT_DFH_OFFSET, 24'h010000: DFH next-header byte offset.
- END_OF_LIST, 1'b0: DFH EOL bit.
- FEATURE_GUID, 128'h0: GUID returned at 0x08 (low 64 bits) and 0x10 (high 64 bits).
- TIMEOUT_CYCLES, 256: forward timeout; used only when the optional feature is compiled in.

Ports:
- clk  in  1  CSR clock.
- rst  in  1  synchronous, active-high reset.
- s_awvalid/s_awready  in/out  1  write address handshake.
- s_awaddr  in  ADDR_W  write byte offset.
- s_wvalid/s_wready  in/out  1  write data handshake.
- s_wdata  in  64  write data.
- s_wstrb  in  8  byte strobes.
- s_bvalid/s_bready  out/in  1  write response handshake.
- s_bresp  out  2  write response.
- s_arvalid/s_arready  in/out  1  read address handshake.
- s_araddr  in  ADDR_W  read byte offset.
- s_rvalid/s_rready  out/in  1  read data handshake.
- s_rdata  out  64  read data.
- s_rresp  out  2  read response.
- uart_req  out  1  forward request; held until ack.
- uart_we  out  1  1 = write.
- uart_addr  out  3  16550 register index.
- uart_wdata  out  8  write byte.
- uart_ack  in  1  single-cycle completion.
- uart_rdata  in  8  read byte, valid with uart_ack.

Behaviour:
- Reset values: all ready/valid outputs 0, uart_req 0, resp 2'b00, s_rdata 0. Reset mid-transaction abandons it: no B/R response is issued and uart_req drops at the reset edge.
- Address map:
  - 0x000 DFH = {4'h3, 19'h0, END_OF_LIST, NEXT_DFH_OFFSET, FEATURE_REV, FEATURE_ID}.
  - 0x008 GUID_L; 0x010 GUID_H.
  - 0x100–0x11C UART window; uart_addr = addr[4:2], byte lane L = addr[2]*4.
  - Everything else is unmapped: reads return 0/OKAY, writes are dropped/OKAY.
  - Writes to DFH/GUID are ignored with OKAY.
- FSM states:
  - IDLE: drives awready = wready = (awvalid & wvalid); drives arready = arvalid & ~(awvalid & wvalid). Write wins a same-cycle tie; the read stays pending.
  - FWD: uart_req = 1; uart_we, uart_addr and uart_wdata are stable until uart_ack.
  - BRESP: bvalid held until bready.
  - RRESP: rvalid held until rready.
- Local read: AR handshake at cycle N → rvalid at N+1.
- UART read:
  - AR at N → uart_req at N+1; ack at cycle M → rvalid at M+1.
  - rdata = byte zero-extended into the addressed 32-bit half; the other half is 0.
  - uart_ack in the same cycle req first asserts is legal.
- UART write:
  - If wstrb[L] = 0: no forward, bvalid at N+1, OKAY.
  - Otherwise forward wdata[8L+:8]; bvalid the cycle after ack.
- Spurious uart_ack outside FWD is ignored.
- No new AW/W/AR is accepted until the response handshake completes: one outstanding transaction.
- Misaligned addresses (addr[1:0] ≠ 0) decode with low bits ignored.

Optional Feature:
- Macro: UART_CSR_FWD_TIMEOUT_EN.
- With the macro: a counter starts at FWD entry. At TIMEOUT_CYCLES cycles without ack, uart_req drops and the FSM goes to the response state with resp = 2'b10 (SLVERR); read data is all-ones 64'hFFFF_FFFF_FFFF_FFFF. A late ack is ignored.
- Without the macro: FWD waits indefinitely, and no counter logic is present.

Decomposition:
- Package uart_csr_pkg holds:
  - Offset constants (DFH_OFF 0x000, GUID_L_OFF 0x008, GUID_H_OFF 0x010, UART_BASE_OFF 0x100, UART_WIN_BYTES 0x20).
  - Packed DFH struct.
  - Resp codes (OKAY 2'b00, SLVERR 2'b10).
  - FSM state enum.
- One sub-module, uart_csr_fwd: the req/ack forward engine plus the optional timeout counter.

Test Plan:
- Read 0x000 with FEATURE_ID = 0x024, NEXT = 0x10000, EOL = 0 → rdata 64'h3000_0001_0000_0024, OKAY, rvalid 1 cycle after AR.
- Write 0x108, wdata[7:0] = 0x5A, wstrb 8'h01 → uart_req with we = 1, addr = 2, wdata = 0x5A. Ack after 3 cycles → bvalid next cycle, OKAY.
- Read 0x114, core returns 0xC3 → rdata 64'h0000_00C3_0000_0000, OKAY.
- AWVALID+WVALID and ARVALID asserted in the same cycle to 0x100 → write completes first; read is accepted only after the B handshake.
- With UART_CSR_FWD_TIMEOUT_EN and no ack on a 0x100 read → uart_req drops after 256 cycles, rresp 2'b10, rdata all-ones. A late ack is ignored.
- Assert rst during FWD → uart_req 0 and no R response; a subsequent read of 0x008 returns GUID[63:0].
